// File: rtl/btn_event_sched.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_sched
// Purpose  : Tick generator, button debounce and round-robin event scheduler.
//            Optional auto-repeat enabled by defining BTN_AUTOREPEAT_EN.
// Revision : 1.0
// ============================================================================
module btn_event_sched #(
    parameter int NUM_BTN      = 5,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_TICKS = 250
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               tick,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [2:0]         evt_id
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CNT - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OFFER = 1'b1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rise_w;
    logic [NUM_BTN-1:0] rep_set_w;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] clr_w;
    logic [0:0]         state_q, state_d;
    logic [2:0]         rr_q, rr_d;
    logic [2:0]         id_q, id_d;
    logic [2:0]         win_w;
    logic               found_w;
    logic               load_w;

    // ---------------- sample tick ----------------
    assign tick  = (div_q == C_DIV_LAST);
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            div_q   <= div_d;
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // ---------------- debounce ----------------
    always_comb begin
        level_d = level_q;
        rise_w  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == C_CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = '0;
                    rise_w[i]  = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
        end else begin
            level_q <= level_d;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_level = level_q;

    // ---------------- auto-repeat ----------------
`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [REP_W-1:0] C_REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [REP_W-1:0] rep_q [NUM_BTN];
    logic [REP_W-1:0] rep_d [NUM_BTN];

    always_comb begin
        rep_set_w = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_d[i] = rep_q[i];
            if ((level_d[i] != level_q[i]) || !level_q[i]) begin
                rep_d[i] = '0;
            end else if (tick) begin
                if (rep_q[i] == C_REP_LAST) begin
                    rep_d[i]     = '0;
                    rep_set_w[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) rep_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) rep_q[i] <= rep_d[i];
        end
    end
`else
    assign rep_set_w = '0;
`endif

    // ---------------- round-robin winner search ----------------
    always_comb begin
        int idx;
        found_w = 1'b0;
        win_w   = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_BTN) idx = idx - NUM_BTN;
            if (!found_w && pending_q[idx]) begin
                found_w = 1'b1;
                win_w   = 3'(idx);
            end
        end
    end

    assign load_w = (state_q == S_IDLE) && found_w;

    // Set beats clear so a press on the button just loaded is not lost.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) clr_w[i] = load_w && (win_w == 3'(i));
        pending_d = (pending_q & ~clr_w) | rise_w | rep_set_w;
        rr_d      = load_w ? win_w : rr_q;
        id_d      = load_w ? win_w : id_q;
    end

    // ---------------- scheduler FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            rr_q      <= 3'(NUM_BTN - 1);
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found_w)   state_d = S_OFFER;
            S_OFFER: if (evt_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        evt_valid = (state_q == S_OFFER);
        evt_id    = id_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_sched
// Purpose  : Scoreboard bench for btn_event_sched (TICK_DIV=4, STABLE_CNT=3).
// Revision : 1.0
// ============================================================================
module tb_btn_event_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic       evt_ready = 1'b0;
    logic       tick;
    logic [4:0] btn_level;
    logic       evt_valid;
    logic [2:0] evt_id;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int cyc   = 0;

    btn_event_sched #(
        .NUM_BTN     (5),
        .TICK_DIV    (4),
        .STABLE_CNT  (3),
        .REPEAT_TICKS(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .tick     (tick),
        .btn_level(btn_level),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each accepted event is matched against the next expected id.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_evt: got id %0d expected none", evt_id);
            end else begin
                check("evt_id_scoreboard", 32'(evt_id), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit, expected normal finish");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns #1 after the n-th clock edge that consumed a tick.
    task automatic wait_ticks(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            while (!tick) @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_all();
        btn_raw = '0;
        wait_ticks(4);
        check("release_level", 32'(btn_level), 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_id", 32'(evt_id), 32'h0);
        for (int c = 1; c <= 8; c++) begin
            step(1);
            check("tick_period", 32'(tick), 32'((c % 4) == 3));
        end

`ifdef BTN_AUTOREPEAT_EN
        begin
            int t[3];
            evt_ready = 1'b1;
            wait_ticks(1);
            btn_raw[4] = 1'b1;
            repeat (3) exp_q.push_back(4);
            for (int k = 0; k < 3; k++) begin
                int n;
                n = 0;
                while (!evt_valid && n < 100) begin
                    step(1);
                    n++;
                end
                check("repeat_seen", 32'(evt_valid), 32'h1);
                t[k] = cyc;
                step(1);
            end
            check("repeat_gap1", 32'(t[1] - t[0]), 32'd20);
            check("repeat_gap2", 32'(t[2] - t[1]), 32'd20);
            btn_raw = '0;
            wait_ticks(6);
            check("repeat_release", 32'(btn_level), 32'h0);
        end
`else
        // Clean press on button 2 with back-pressure.
        evt_ready = 1'b0;
        wait_ticks(1);
        btn_raw[2] = 1'b1;
        exp_q.push_back(2);
        wait_ticks(2);
        check("press_level_early", 32'(btn_level), 32'h0);
        wait_ticks(1);
        check("press_level", 32'(btn_level), 32'h04);
        check("press_valid_lat0", 32'(evt_valid), 32'h0);
        step(1);
        check("press_valid", 32'(evt_valid), 32'h1);
        check("press_id", 32'(evt_id), 32'd2);
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("hold_valid", 32'(evt_valid), 32'h1);
            check("hold_id", 32'(evt_id), 32'd2);
        end
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check("accept_valid", 32'(evt_valid), 32'h0);
        evt_ready = 1'b1;
        release_all();

        // Glitch shorter than the stable window.
        btn_raw[1] = 1'b1;
        wait_ticks(2);
        btn_raw[1] = 1'b0;
        wait_ticks(4);
        check("glitch_level", 32'(btn_level), 32'h0);
        check("glitch_valid", 32'(evt_valid), 32'h0);

        // Round-robin: btn0 alone, then btn0+btn3 together.
        btn_raw[0] = 1'b1;
        exp_q.push_back(0);
        wait_ticks(3);
        check("rr_level0", 32'(btn_level), 32'h01);
        step(3);
        release_all();
        exp_q.push_back(3);
        exp_q.push_back(0);
        btn_raw = 5'b01001;
        wait_ticks(3);
        check("rr_level03", 32'(btn_level), 32'h09);
        step(1);
        check("rr_first_valid", 32'(evt_valid), 32'h1);
        check("rr_first_id", 32'(evt_id), 32'd3);
        step(1);
        check("rr_gap_valid", 32'(evt_valid), 32'h0);
        step(1);
        check("rr_second_valid", 32'(evt_valid), 32'h1);
        check("rr_second_id", 32'(evt_id), 32'd0);
        step(2);
        release_all();

        // Coalescing: three presses while stalled give two events.
        evt_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            btn_raw[1] = 1'b1;
            wait_ticks(3);
            btn_raw[1] = 1'b0;
            wait_ticks(3);
        end
        exp_q.push_back(1);
        exp_q.push_back(1);
        check("coal_valid", 32'(evt_valid), 32'h1);
        check("coal_id", 32'(evt_id), 32'd1);
        evt_ready = 1'b1;
        step(20);
        check("coal_drained", 32'(exp_q.size()), 32'd0);
        check("coal_idle", 32'(evt_valid), 32'h0);

        // Reset while offering with another button pending.
        evt_ready = 1'b0;
        btn_raw = 5'b10100;
        wait_ticks(3);
        step(2);
        check("mid_valid", 32'(evt_valid), 32'h1);
        check("mid_id", 32'(evt_id), 32'd2);
        rst = 1'b1;
        btn_raw = '0;
        step(1);
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_level", 32'(btn_level), 32'h0);
        check("mid_rst_tick", 32'(tick), 32'h0);
        step(2);
        rst = 1'b0;
        evt_ready = 1'b1;
        step(40);
        check("post_rst_valid", 32'(evt_valid), 32'h0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
